// File: rtl/latch_wr_pkg.sv
// Shared types and sizing helpers for the latch bank write controller.
// LATCH_WR_PARITY_EN adds an even-parity bit on top of the latch data bus.
package latch_wr_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      GATE  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   localparam int DEF_SETUP_CYC = 1;
   localparam int DEF_GATE_CYC  = 2;
   localparam int DEF_HOLD_CYC  = 1;

`ifdef LATCH_WR_PARITY_EN
   localparam int PAR_W = 1;
`else
   localparam int PAR_W = 0;
`endif

   function automatic int cnt_w(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

   localparam int PHASE_MAX = max3(DEF_SETUP_CYC, DEF_GATE_CYC, DEF_HOLD_CYC);

endpackage

// File: rtl/latch_wr_timer.sv
// Load/expire down-counter that times each phase of the latch write sequence.
// expire is high during the final cycle of the loaded interval; expire_nxt is its next value.
module latch_wr_timer #(
   parameter int CNT_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expire,
   output logic             expire_nxt
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expire_q;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - ONE;
      end
   end

   assign expire_nxt = (cnt_d == ONE);
   assign expire     = expire_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         expire_q <= 1'b0;
      end else begin
         cnt_q    <= cnt_d;
         expire_q <= expire_nxt;
      end
   end

endmodule

// File: rtl/latch_bank_writer.sv
// Write controller for a bank of transparent D latches: setup, one-hot gate pulse, hold.
// Define LATCH_WR_PARITY_EN to append even parity of the written data as lat_din[DATA_W].
module latch_bank_writer
   import latch_wr_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int NUM_LATCH = 4,
   parameter int ADDR_W    = (NUM_LATCH > 1) ? $clog2(NUM_LATCH) : 1,
   parameter int SETUP_CYC = DEF_SETUP_CYC,
   parameter int GATE_CYC  = DEF_GATE_CYC,
   parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      wr_valid,
   output logic                      wr_ready,
   input  logic [ADDR_W-1:0]         wr_addr,
   input  logic [DATA_W-1:0]         wr_data,
   output logic [DATA_W+PAR_W-1:0]   lat_din,
   output logic [NUM_LATCH-1:0]      lat_gate,
   output logic                      busy,
   output logic                      done,
   output logic                      addr_err
);

   localparam int DW      = DATA_W + PAR_W;
   localparam int TMR_MAX = max3(SETUP_CYC, GATE_CYC, HOLD_CYC);
   localparam int CW      = cnt_w(TMR_MAX);
   localparam logic [ADDR_W:0] NUM_L = (ADDR_W + 1)'(NUM_LATCH);

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 addr_bad_q, addr_bad_d;
   logic [DW-1:0]        din_q, din_d, cap_din;
   logic [NUM_LATCH-1:0] gate_q, gate_d, gate_dec;
   logic                 ready_q, ready_d;
   logic                 busy_q, busy_d;
   logic                 done_q, done_d;
   logic                 err_q, err_d;
   logic                 accept;
   logic                 tmr_load, tmr_expire, tmr_expire_nxt;
   logic [CW-1:0]        tmr_val;

   assign accept = wr_valid && ready_q;

`ifdef LATCH_WR_PARITY_EN
   assign cap_din = {^wr_data, wr_data};
`else
   assign cap_din = wr_data;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LATCH; gi++) begin : g_dec
         assign gate_dec[gi] = (addr_q == ADDR_W'(gi));
      end
   endgenerate

   latch_wr_timer #(
      .CNT_W (CW)
   ) u_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (tmr_load),
      .load_val   (tmr_val),
      .expire     (tmr_expire),
      .expire_nxt (tmr_expire_nxt)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      addr_bad_d = addr_bad_q;
      din_d      = din_q;
      done_d     = 1'b0;
      err_d      = 1'b0;
      tmr_load   = 1'b0;
      tmr_val    = CW'(SETUP_CYC);

      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d    = SETUP;
               addr_d     = wr_addr;
               addr_bad_d = ({1'b0, wr_addr} >= NUM_L);
               din_d      = cap_din;
               tmr_load   = 1'b1;
               tmr_val    = CW'(SETUP_CYC);
            end
         end
         SETUP: begin
            if (tmr_expire) begin
               state_d  = GATE;
               tmr_load = 1'b1;
               tmr_val  = CW'(GATE_CYC);
            end
         end
         GATE: begin
            if (tmr_expire) begin
               state_d  = HOLD;
               tmr_load = 1'b1;
               tmr_val  = CW'(HOLD_CYC);
            end
         end
         HOLD: begin
            if (tmr_expire) begin
               done_d = 1'b1;
               err_d  = addr_bad_q;
               // Completion edge doubles as the next handshake, so writes stream without bubbles.
               if (accept) begin
                  state_d    = SETUP;
                  addr_d     = wr_addr;
                  addr_bad_d = ({1'b0, wr_addr} >= NUM_L);
                  din_d      = cap_din;
                  tmr_load   = 1'b1;
                  tmr_val    = CW'(SETUP_CYC);
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      busy_d  = (state_d != IDLE);
      gate_d  = ((state_d == GATE) && !addr_bad_q) ? gate_dec : '0;
      // Ready opens in the last hold cycle so a waiting write is taken on the completion edge.
      ready_d = (state_d == IDLE) || ((state_d == HOLD) && tmr_expire_nxt);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         addr_q     <= '0;
         addr_bad_q <= 1'b0;
         din_q      <= '0;
         gate_q     <= '0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         addr_bad_q <= addr_bad_d;
         din_q      <= din_d;
         gate_q     <= gate_d;
         ready_q    <= ready_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign wr_ready = ready_q;
   assign lat_din  = din_q;
   assign lat_gate = gate_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign addr_err = err_q;

endmodule

// File: tb/tb_latch_bank_writer.sv
// Bench for latch_bank_writer: a 4-latch and a 3-latch instance share stimulus and are checked
// every cycle against an interval-based reference model. Honors LATCH_WR_PARITY_EN.
module tb_latch_bank_writer;

   localparam int DATA_W = 8;
   localparam int S      = 1;
   localparam int G      = 2;
   localparam int H      = 1;
   localparam int T      = S + G + H;
   localparam int NCYC   = 600;
`ifdef LATCH_WR_PARITY_EN
   localparam int DW = DATA_W + 1;
`else
   localparam int DW = DATA_W;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst_n, wr_valid;
   logic [1:0]        wr_addr;
   logic [DATA_W-1:0] wr_data;

   logic          rdy4, busy4, done4, err4;
   logic [DW-1:0] din4;
   logic [3:0]    gate4;
   logic          rdy3, busy3, done3, err3;
   logic [DW-1:0] din3;
   logic [2:0]    gate3;

   latch_bank_writer #(
      .DATA_W(DATA_W), .NUM_LATCH(4), .ADDR_W(2),
      .SETUP_CYC(S), .GATE_CYC(G), .HOLD_CYC(H)
   ) dut4 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy4),
      .wr_addr(wr_addr), .wr_data(wr_data), .lat_din(din4), .lat_gate(gate4),
      .busy(busy4), .done(done4), .addr_err(err4)
   );

   latch_bank_writer #(
      .DATA_W(DATA_W), .NUM_LATCH(3), .ADDR_W(2),
      .SETUP_CYC(S), .GATE_CYC(G), .HOLD_CYC(H)
   ) dut3 (
      .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(rdy3),
      .wr_addr(wr_addr), .wr_data(wr_data), .lat_din(din3), .lat_gate(gate3),
      .busy(busy3), .done(done3), .addr_err(err3)
   );

   int ncmp = 0;
   int nerr = 0;
   int k = 0;
   int next_free = 0;

   // Per-edge expectations: each accepted write paints its timed intervals into these.
   logic [3:0]    g4_exp   [NCYC];
   logic [2:0]    g3_exp   [NCYC];
   bit            busy_exp [NCYC];
   bit            done_exp [NCYC];
   bit            err3_exp [NCYC];
   logic [DW-1:0] din_exp;

   function automatic logic [DW-1:0] exp_din(input logic [DATA_W-1:0] d);
`ifdef LATCH_WR_PARITY_EN
      return {^d, d};
`else
      return d;
`endif
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s edge %0d: observed %h expected %h", tag, k, obs, exp);
      end
   endtask

   task automatic step(input bit v, input logic [1:0] a, input logic [DATA_W-1:0] d, input bit r);
      bit accepted;
      logic rdy_exp;
      rst_n    = r;
      wr_valid = v;
      wr_addr  = a;
      wr_data  = d;
      accepted = 1'b0;
      @(posedge clk);
      if (!r) begin
         for (int j = k; j < NCYC; j++) begin
            g4_exp[j] = '0; g3_exp[j] = '0;
            busy_exp[j] = 1'b0; done_exp[j] = 1'b0; err3_exp[j] = 1'b0;
         end
         din_exp   = '0;
         next_free = k + 2;
      end else if (v && k >= next_free) begin
         accepted  = 1'b1;
         next_free = k + T;
         for (int j = k; j < k + T; j++) busy_exp[j] = 1'b1;
         for (int j = k + S; j < k + S + G; j++) begin
            g4_exp[j] = 4'(1) << a;
            g3_exp[j] = (a < 2'd3) ? (3'(1) << a) : 3'b000;
         end
         done_exp[k + T] = 1'b1;
         err3_exp[k + T] = (a == 2'd3);
         din_exp = exp_din(d);
      end
      rdy_exp = r && (k + 1 >= next_free);
      #1;
      check("din4",  32'(din4),  32'(din_exp));
      check("din3",  32'(din3),  32'(din_exp));
      check("gate4", 32'(gate4), 32'(g4_exp[k]));
      check("gate3", 32'(gate3), 32'(g3_exp[k]));
      check("busy4", 32'(busy4), 32'(busy_exp[k]));
      check("busy3", 32'(busy3), 32'(busy_exp[k]));
      check("done4", 32'(done4), 32'(done_exp[k]));
      check("done3", 32'(done3), 32'(done_exp[k]));
      check("err4",  32'(err4),  32'(0));
      check("err3",  32'(err3),  32'(err3_exp[k]));
      check("rdy4",  32'(rdy4),  32'(rdy_exp));
      check("rdy3",  32'(rdy3),  32'(rdy_exp));
      $display("edge %0d rst_n=%0b valid=%0b addr=%0d data=%h acc=%0b | din=%h gate4=%b gate3=%b done=%0b err3=%0b rdy=%0b",
               k, r, v, a, d, accepted, din4, gate4, gate3, done4, err3, rdy4);
      k++;
   endtask

   initial begin
      for (int j = 0; j < NCYC; j++) begin
         g4_exp[j] = '0; g3_exp[j] = '0;
         busy_exp[j] = 1'b0; done_exp[j] = 1'b0; err3_exp[j] = 1'b0;
      end
      din_exp = '0;

      // Reset with valid asserted (must be ignored), then release.
      step(1'b1, 2'd1, 8'hFF, 1'b0);
      step(1'b0, 2'd0, 8'h00, 1'b0);
      step(1'b0, 2'd0, 8'h00, 1'b0);
      step(1'b0, 2'd0, 8'h00, 1'b1);

      // Single write to latch 2.
      step(1'b1, 2'd2, 8'hA5, 1'b1);
      repeat (4) step(1'b0, 2'd0, 8'h00, 1'b1);

      // Back-to-back with valid held.
      step(1'b1, 2'd0, 8'h11, 1'b1);
      repeat (4) step(1'b1, 2'd3, 8'h22, 1'b1);
      repeat (5) step(1'b0, 2'd0, 8'h00, 1'b1);

      // Address 3: out of range for the 3-latch instance only.
      step(1'b1, 2'd3, 8'h3C, 1'b1);
      repeat (4) step(1'b0, 2'd0, 8'h00, 1'b1);

      // Reset two edges after a handshake, during the gate pulse.
      step(1'b1, 2'd1, 8'h5A, 1'b1);
      step(1'b0, 2'd0, 8'h00, 1'b1);
      step(1'b0, 2'd0, 8'h00, 1'b0);
      repeat (5) step(1'b0, 2'd0, 8'h00, 1'b1);

      // Parity-sensitive data patterns.
      step(1'b1, 2'd0, 8'h07, 1'b1);
      repeat (4) step(1'b0, 2'd0, 8'h00, 1'b1);
      step(1'b1, 2'd1, 8'h03, 1'b1);
      repeat (4) step(1'b0, 2'd0, 8'h00, 1'b1);

      // Random traffic with occasional resets.
      while (k < NCYC - T - 2) begin
         step(($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
              8'($urandom), ($urandom_range(0, 49) != 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
